vga_layer_mixer: RTL and testbench
==================================

# vga_layer_mixer

Display back end that drives the pixel-coordinate bus consumed by every drawing block and merges their registered per-pixel outputs into the final VGA signal. It owns the 800x600@72 Hz raster counters, presents `x`/`y` to all drawing layers, and selects one colour per pixel from up to `NUM_LAYERS` `{r,g,b,dav}` streams by fixed priority. It delays sync and blanking so they stay aligned with the layers' one-cycle registered outputs, and it generates the frame tick used by game logic.

## Interface
- `H_VISIBLE`, 800: active pixels per line
- `H_FP`, 56: horizontal front porch, in pixels
- `H_SYNC`, 120: horizontal sync width, in pixels
- `H_BP`, 64: horizontal back porch, in pixels
- `V_VISIBLE`, 600: active lines per frame
- `V_FP`, 37: vertical front porch, in lines
- `V_SYNC`, 6: vertical sync width, in lines
- `V_BP`, 23: vertical back porch, in lines
- `SYNC_ACTIVE`, 1: sync polarity (1 = active-high)
- `NUM_LAYERS`, 4: number of drawing layers (1..8)
- `BG_RGB`, 6'b000000: background colour `{r,g,b}`, 2 bits each
- `vga_clk`  in  1  pixel clock, 50 MHz
- `rst`  in  1  reset; asynchronous, active-high
- `x`  out  11  current horizontal count, 0..H_TOTAL-1
- `y`  out  10  current vertical count, 0..V_TOTAL-1
- `layer_rgb`  in  6*NUM_LAYERS  per-layer colour; layer i occupies `[6i+5:6i]` as `{r[1:0],g[1:0],b[1:0]}`
- `layer_dav`  in  NUM_LAYERS  per-layer pixel-valid flag
- `vga_r`, `vga_g`, `vga_b`  out  2 each  colour to the DAC
- `vga_hsync`, `vga_vsync`  out  1 each  sync outputs
- `frame_tick`  out  1  one-cycle pulse at the start of each frame

## Operation
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP = 1040. V_TOTAL = 666.
- `x` increments every cycle. At H_TOTAL-1, `x` wraps to 0 and `y` increments; `y` wraps to 0 after V_TOTAL-1. Both are counter registers and are never combinational.
- Counter-stage flags, computed from `x`/`y`:
  - `active` = (x < H_VISIBLE) && (y < V_VISIBLE)
  - `hs` = x in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1]
  - `vs` = y in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1]
- Drawing layers register their output one cycle after sampling `x`/`y`. The flags therefore pass through a 1-stage delay so they align with `layer_*`.
- Mix stage, one register:
  - If delayed `active` = 0, the colour output is 0.
  - Otherwise the lowest index i with `layer_dav[i]` = 1 wins, and its `layer_rgb` is output.
  - With no `dav` set, `BG_RGB` is output.
- Sync outputs are registered in the same mix stage: `vga_hsync` = delayed `hs` XNOR `SYNC_ACTIVE`-inverted, i.e. active level equals `SYNC_ACTIVE` while asserted. `vga_vsync` works the same way.
- `frame_tick` = 1 for the one cycle in which `x`=0 && `y`=0; registered, aligned with the counters.
- Layer inputs are only meaningful one cycle after the corresponding `x`/`y`. `dav` during blanking is ignored.

## Timing
- Reset (async assert, sync release on `vga_clk`):
  - `x`=0, `y`=0, `frame_tick`=0
  - colour outputs = 0
  - syncs at the inactive level (`!SYNC_ACTIVE`)
  - delay registers cleared to inactive
- First cycle after reset release: `x`=1, and `frame_tick` is not pulsed for the reset frame. The first pulse occurs at the next wrap to (0,0).
- Latency:
  - `x`/`y` at cycle t
  - layer outputs valid at t+1
  - `vga_*` colour, `vga_hsync`, `vga_vsync` reflect pixel (x,y) at t+2
- Sync and colour are always co-aligned: hsync assertion for a line is 2 cycles after `x` = 856.
- Reset asserted mid-frame: all outputs go to reset values immediately, without waiting for a clock edge. No partial line completes.
- Wrap boundary: at (`x`,`y`) = (1039,665), the next cycle is (0,0) and `frame_tick` = 1 for exactly that cycle.
- Simultaneous `dav` on several layers: only the priority winner's colour appears. There is no blending.

## Test plan
- Reset, then run 2 frames. Check that `x` spans 0..1039 and `y` spans 0..665, with exactly 1040*666 = 692,640 cycles between `frame_tick` pulses.
- Sync check (`SYNC_ACTIVE`=1):
  - `vga_hsync` high for exactly 120 cycles per line, rising 858 cycles after the cycle where `x`=0 (856+2).
  - `vga_vsync` high for 6 lines, starting on line 637.
- Layer model drives `dav`=1 on layer 2 with rgb 6'b110000 for `x`=136, `y`=125 (registered). The pixel sampled 2 cycles after (`x`,`y`)=(136,125) must be `vga_r`=3, `g`=0, `b`=0; neighbouring pixels must be `BG_RGB`.
- Layers 0 and 3 both assert `dav` at the same pixel, with rgb 6'b001111 and 6'b111100. The output must be layer 0's colour (r=0, g=3, b=3).
- Layer `dav`=1 held constantly with rgb 6'b111111. Colour must be 0 whenever the delayed position is in blanking (x≥800 or y≥600), and 6'b111111 otherwise.
- Assert `rst` asynchronously at (`x`,`y`)=(400,300) between clock edges. All outputs must reset before the next edge. After release, counting must restart from 0 and no `frame_tick` may occur until the following wrap.

Source files
------------

// File: rtl/vga_layer_mixer_if.sv
// Pixel bus between the display back end and the drawing layers.
// The mixer (master) publishes the raster position and the final VGA
// signals; the drawing layers (slave) return one registered colour/valid
// pair per layer, one cycle after sampling x/y.
interface vga_layer_mixer_if #(
  parameter int NUM_LAYERS = 4
);
  logic [10:0]              x;
  logic [9:0]               y;
  logic [6*NUM_LAYERS-1:0]  layer_rgb;
  logic [NUM_LAYERS-1:0]    layer_dav;
  logic [1:0]               vga_r;
  logic [1:0]               vga_g;
  logic [1:0]               vga_b;
  logic                     vga_hsync;
  logic                     vga_vsync;
  logic                     frame_tick;

  modport master (
    output x, y, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, frame_tick,
    input  layer_rgb, layer_dav
  );

  modport slave (
    input  x, y, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, frame_tick,
    output layer_rgb, layer_dav
  );
endinterface

// File: rtl/vga_layer_mixer.sv
// Display back end: raster counters, fixed-priority layer mixer and
// sync generation. Position is presented at cycle t, the layers answer at
// t+1 and the mixed pixel with its matching syncs leaves at t+2.
module vga_layer_mixer #(
  parameter int         H_VISIBLE   = 800,
  parameter int         H_FP        = 56,
  parameter int         H_SYNC      = 120,
  parameter int         H_BP        = 64,
  parameter int         V_VISIBLE   = 600,
  parameter int         V_FP        = 37,
  parameter int         V_SYNC      = 6,
  parameter int         V_BP        = 23,
  parameter logic       SYNC_ACTIVE = 1'b1,
  parameter int         NUM_LAYERS  = 4,
  parameter logic [5:0] BG_RGB      = 6'b000000
) (
  input  logic               vga_clk,
  input  logic               rst,
  vga_layer_mixer_if.master  bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Sized raster landmarks so every compare is width-matched.
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT_END  = 11'(H_VISIBLE);
  localparam logic [10:0] HS_FIRST   = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_LAST    = 11'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT_END  = 10'(V_VISIBLE);
  localparam logic [9:0]  VS_FIRST   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]  VS_LAST    = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  // Counter stage
  logic [10:0] x_r;
  logic [10:0] x_next_s;
  logic [9:0]  y_r;
  logic [9:0]  y_next_s;
  logic        wrap_s;
  logic        frame_tick_r;

  // Flags of the position currently on the bus
  logic        active_s;
  logic        hs_s;
  logic        vs_s;

  // Flags delayed by one cycle to line up with the layers' answers
  logic        active_d_r;
  logic        hs_d_r;
  logic        vs_d_r;

  // Mix stage
  logic [5:0]  pick_rgb_s;
  logic [5:0]  rgb_r;
  logic        hsync_r;
  logic        vsync_r;

  // Next raster position and end-of-frame detection.
  always_comb begin
    x_next_s = 11'd0;
    y_next_s = y_r;
    wrap_s   = 1'b0;
    if (x_r == H_LAST) begin
      x_next_s = 11'd0;
      if (y_r == V_LAST) begin
        y_next_s = 10'd0;
        wrap_s   = 1'b1;
      end else begin
        y_next_s = y_r + 10'd1;
      end
    end else begin
      x_next_s = x_r + 11'd1;
    end
  end

  // Raster counters; frame_tick rises together with the wrap to (0,0), so
  // the position held during reset never produces a pulse.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      x_r          <= 11'd0;
      y_r          <= 10'd0;
      frame_tick_r <= 1'b0;
    end else begin
      x_r          <= x_next_s;
      y_r          <= y_next_s;
      frame_tick_r <= wrap_s;
    end
  end

  // Visibility and sync windows of the position on the bus.
  always_comb begin
    active_s = (x_r < H_ACT_END) && (y_r < V_ACT_END);
    hs_s     = (x_r >= HS_FIRST) && (x_r <= HS_LAST);
    vs_s     = (y_r >= VS_FIRST) && (y_r <= VS_LAST);
  end

  // One-cycle flag delay matching the registered layer outputs.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      active_d_r <= 1'b0;
      hs_d_r     <= 1'b0;
      vs_d_r     <= 1'b0;
    end else begin
      active_d_r <= active_s;
      hs_d_r     <= hs_s;
      vs_d_r     <= vs_s;
    end
  end

  // Fixed priority: scanning from the highest index down lets the lowest
  // valid layer overwrite everything above it; no valid layer leaves BG.
  always_comb begin
    pick_rgb_s = BG_RGB;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      pick_rgb_s = bus.layer_dav[i] ? bus.layer_rgb[6*i +: 6] : pick_rgb_s;
    end
  end

  // Mix register: colour is forced black in blanking, syncs are mapped to
  // the configured polarity in the same stage so they stay co-aligned.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      rgb_r   <= 6'b000000;
      hsync_r <= ~SYNC_ACTIVE;
      vsync_r <= ~SYNC_ACTIVE;
    end else begin
      if (active_d_r) begin
        rgb_r <= pick_rgb_s;
      end else begin
        rgb_r <= 6'b000000;
      end
      hsync_r <= hs_d_r ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_r <= vs_d_r ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end

  assign bus.x          = x_r;
  assign bus.y          = y_r;
  assign bus.frame_tick = frame_tick_r;
  assign bus.vga_r      = rgb_r[5:4];
  assign bus.vga_g      = rgb_r[3:2];
  assign bus.vga_b      = rgb_r[1:0];
  assign bus.vga_hsync  = hsync_r;
  assign bus.vga_vsync  = vsync_r;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Bench for vga_layer_mixer on a shrunken raster (32x17 total) so several
// frames fit in a short run. A layer model answers every position one cycle
// late; expected pixels are queued per position and popped two cycles later.
`timescale 1ns/1ps
module tb_vga_layer_mixer;

  localparam int HV = 20, HF = 3, HSW = 5, HB = 4;
  localparam int VV = 10, VF = 2, VSW = 3, VB = 2;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam int FRAME = HT * VT;
  localparam int NL = 4;
  localparam logic [5:0] BG = 6'b010110;
  localparam logic SA = 1'b1;

  typedef struct {
    int         px;
    int         py;
    logic [3:0]  dav;
    logic [23:0] rgb;
    logic [5:0]  exp_rgb;
  } vec_t;

  typedef struct {
    logic [5:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;

  logic vga_clk = 1'b0;
  logic rst = 1'b1;

  vga_layer_mixer_if #(.NUM_LAYERS(NL)) bus ();

  vga_layer_mixer #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .SYNC_ACTIVE(SA), .NUM_LAYERS(NL), .BG_RGB(BG)
  ) dut (
    .vga_clk(vga_clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 vga_clk = ~vga_clk;

  vec_t tbl [11];
  exp_t sb [$];
  int total = 0;
  int bad = 0;
  int mode = 0;
  int mx = 0, my = 0;
  int cyc = 0;
  int line_start = 0;
  int last_tick = -1;
  int hs_cnt = 0, vs_cnt = 0;
  bit hs_trk = 1'b0, vs_trk = 1'b0;
  logic prev_hs = 1'b0, prev_vs = 1'b0;
  logic [3:0]  pend_dav;
  logic [23:0] pend_rgb;

  // Lowest-index valid layer, or background when none is valid.
  function automatic logic [5:0] prio(input logic [3:0] dav, input logic [23:0] rgb);
    int k;
    k = 0;
    while (k < NL && !dav[k]) k++;
    if (k == NL) return BG;
    return rgb[6*k +: 6];
  endfunction

  // Layer answer for one position plus the pixel it must produce.
  task automatic make_layer(input int px, input int py,
                            output logic [3:0] dav, output logic [23:0] rgb,
                            output exp_t e);
    bit act;
    int hit;
    act  = (px < HV) && (py < VV);
    e.hs = ((px >= HV + HF) && (px < HV + HF + HSW)) ? SA : ~SA;
    e.vs = ((py >= VV + VF) && (py < VV + VF + VSW)) ? SA : ~SA;
    dav  = 4'b0000;
    rgb  = 24'h000000;
    case (mode)
      0: begin
        hit = -1;
        for (int i = 0; i < 11; i++)
          if (tbl[i].px == px && tbl[i].py == py) hit = i;
        if (hit >= 0) begin
          dav   = tbl[hit].dav;
          rgb   = tbl[hit].rgb;
          e.rgb = tbl[hit].exp_rgb;
        end else begin
          e.rgb = act ? BG : 6'b000000;
        end
      end
      1: begin
        dav   = 4'($urandom);
        rgb   = 24'($urandom);
        e.rgb = act ? prio(dav, rgb) : 6'b000000;
      end
      default: begin
        dav   = {3'($urandom), 1'b1};
        rgb   = {18'($urandom), 6'b111111};
        e.rgb = act ? 6'b111111 : 6'b000000;
      end
    endcase
  endtask

  task automatic check_reset(input string name);
    total++;
    if (bus.x !== 11'd0 || bus.y !== 10'd0 || bus.frame_tick !== 1'b0 ||
        {bus.vga_r, bus.vga_g, bus.vga_b} !== 6'b000000 ||
        bus.vga_hsync !== ~SA || bus.vga_vsync !== ~SA) begin
      bad++;
      $display("FAIL %s: x=%0d y=%0d tick=%b rgb=%b hs=%b vs=%b, want all zero with syncs=%b",
               name, bus.x, bus.y, bus.frame_tick, {bus.vga_r, bus.vga_g, bus.vga_b},
               bus.vga_hsync, bus.vga_vsync, ~SA);
    end
  endtask

  // Called right after rst drops: the bus shows (0,0) until the next edge.
  task automatic release_init();
    logic [3:0] d;
    logic [23:0] r;
    exp_t e;
    mx = 0;
    my = 0;
    sb.delete();
    make_layer(0, 0, d, r, e);
    pend_dav = d;
    pend_rgb = r;
    sb.push_back(e);
    line_start = cyc;
    last_tick = -1;
    prev_hs = 1'b0;
    prev_vs = 1'b0;
    hs_trk = 1'b0;
    vs_trk = 1'b0;
  endtask

  task automatic step();
    logic [3:0] d;
    logic [23:0] r;
    exp_t e, ex;
    logic exp_tick;
    @(posedge vga_clk);
    #1;
    cyc++;
    exp_tick = 1'b0;
    if (mx == HT - 1) begin
      mx = 0;
      if (my == VT - 1) begin
        my = 0;
        exp_tick = 1'b1;
      end else begin
        my++;
      end
    end else begin
      mx++;
    end
    bus.layer_dav = pend_dav;
    bus.layer_rgb = pend_rgb;

    total++;
    if (bus.x !== 11'(mx) || bus.y !== 10'(my) || bus.frame_tick !== exp_tick) begin
      bad++;
      $display("FAIL pos: x=%0d y=%0d tick=%b, want x=%0d y=%0d tick=%b",
               bus.x, bus.y, bus.frame_tick, mx, my, exp_tick);
    end

    if (sb.size() == 2) begin
      ex = sb.pop_front();
      total++;
      if ({bus.vga_r, bus.vga_g, bus.vga_b} !== ex.rgb ||
          bus.vga_hsync !== ex.hs || bus.vga_vsync !== ex.vs) begin
        bad++;
        $display("FAIL pixel: rgb=%b hs=%b vs=%b, want rgb=%b hs=%b vs=%b (bus x=%0d y=%0d)",
                 {bus.vga_r, bus.vga_g, bus.vga_b}, bus.vga_hsync, bus.vga_vsync,
                 ex.rgb, ex.hs, ex.vs, mx, my);
      end
    end

    make_layer(mx, my, d, r, e);
    pend_dav = d;
    pend_rgb = r;
    sb.push_back(e);

    if (bus.frame_tick === 1'b1) begin
      if (last_tick >= 0) begin
        total++;
        if (cyc - last_tick != FRAME) begin
          bad++;
          $display("FAIL tick_period: %0d cycles, want %0d", cyc - last_tick, FRAME);
        end
      end
      last_tick = cyc;
    end

    if (mx == 0) line_start = cyc;
    if (bus.vga_hsync === SA && prev_hs !== SA) begin
      total++;
      if (cyc - line_start != HV + HF + 2) begin
        bad++;
        $display("FAIL hs_rise: %0d cycles after x=0, want %0d", cyc - line_start, HV + HF + 2);
      end
      hs_cnt = 0;
      hs_trk = 1'b1;
    end
    if (bus.vga_hsync === SA) hs_cnt++;
    if (bus.vga_hsync !== SA && prev_hs === SA && hs_trk) begin
      total++;
      if (hs_cnt != HSW) begin
        bad++;
        $display("FAIL hs_width: %0d cycles, want %0d", hs_cnt, HSW);
      end
    end

    if (bus.vga_vsync === SA && prev_vs !== SA) begin
      total++;
      if (bus.y !== 10'(VV + VF) || bus.x !== 11'd2) begin
        bad++;
        $display("FAIL vs_rise: at x=%0d y=%0d, want x=2 y=%0d", bus.x, bus.y, VV + VF);
      end
      vs_cnt = 0;
      vs_trk = 1'b1;
    end
    if (bus.vga_vsync === SA) vs_cnt++;
    if (bus.vga_vsync !== SA && prev_vs === SA && vs_trk) begin
      total++;
      if (vs_cnt != VSW * HT) begin
        bad++;
        $display("FAIL vs_width: %0d cycles, want %0d", vs_cnt, VSW * HT);
      end
    end
    prev_hs = bus.vga_hsync;
    prev_vs = bus.vga_vsync;
  endtask

  initial begin
    tbl[0]  = '{7,  4,  4'b0100, {6'b000000, 6'b110000, 6'b000000, 6'b000000}, 6'b110000};
    tbl[1]  = '{6,  4,  4'b0000, 24'h000000, BG};
    tbl[2]  = '{8,  4,  4'b0000, 24'h000000, BG};
    tbl[3]  = '{5,  3,  4'b1001, {6'b111100, 6'b000000, 6'b000000, 6'b001111}, 6'b001111};
    tbl[4]  = '{0,  0,  4'b0010, {6'b000000, 6'b000000, 6'b101010, 6'b000000}, 6'b101010};
    tbl[5]  = '{19, 9,  4'b1000, {6'b011011, 18'h00000}, 6'b011011};
    tbl[6]  = '{20, 9,  4'b0001, {18'h00000, 6'b111111}, 6'b000000};
    tbl[7]  = '{3,  10, 4'b0001, {18'h00000, 6'b111111}, 6'b000000};
    tbl[8]  = '{10, 2,  4'b1110, {6'b111111, 6'b110000, 6'b000011, 6'b000000}, 6'b000011};
    tbl[9]  = '{11, 2,  4'b1100, {6'b111111, 6'b100100, 12'h000}, 6'b100100};
    tbl[10] = '{31, 16, 4'b1111, {6'b111111, 6'b111111, 6'b111111, 6'b111111}, 6'b000000};

    bus.layer_dav = 4'b0000;
    bus.layer_rgb = 24'h000000;
    pend_dav = 4'b0000;
    pend_rgb = 24'h000000;

    repeat (3) @(posedge vga_clk);
    #1;
    check_reset("reset_state");

    // Table frame, then random priority frame, then constant-valid frame.
    mode = 0;
    rst = 1'b0;
    release_init();
    for (int i = 0; i < FRAME + 5; i++) step();
    mode = 1;
    for (int i = 0; i < FRAME; i++) step();
    mode = 2;
    for (int i = 0; i < FRAME; i++) step();

    // Asynchronous reset in the middle of a visible line.
    mode = 1;
    for (int i = 0; i < FRAME && !(mx == 10 && my == 5); i++) step();
    total++;
    if (!(mx == 10 && my == 5)) begin
      bad++;
      $display("FAIL reach_pos: at x=%0d y=%0d, want x=10 y=5", mx, my);
    end
    #3;
    rst = 1'b1;
    #1;
    check_reset("async_reset");
    bus.layer_dav = 4'b0000;
    bus.layer_rgb = 24'h000000;
    repeat (2) @(posedge vga_clk);
    #1;
    check_reset("reset_hold");

    mode = 0;
    rst = 1'b0;
    release_init();
    for (int i = 0; i < FRAME + 40; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
